// File: rtl/axi_pkg.sv
`default_nettype none
// =============================================================================
// Module  : axi_pkg
// Brief   : AXI4-Lite response codes and FSM state encodings for the dmem slave
// Revision: 1.0 - initial release
// =============================================================================
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_WAIT_W  = 2'd1,
      W_WAIT_AW = 2'd2,
      W_RESP    = 2'd3
   } wState_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rState_t;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// =============================================================================
// Module  : dmem_array
// Brief   : DEPTH x 32 storage, one synchronous read port, one byte-masked write
// Revision: 1.0 - initial release
// =============================================================================
module dmem_array #(
   parameter int DEPTH  = 256,
   parameter int MEM_AW = 8
) (
   input  logic              clk,
   input  logic              i_rdEn,
   input  logic [MEM_AW-1:0] i_rdIdx,
   output logic [31:0]       o_rdData,
   input  logic              i_wrEn,
   input  logic [MEM_AW-1:0] i_wrIdx,
   input  logic [31:0]       i_wrData,
   input  logic [3:0]        i_wrStrb
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdData;

   // Contents are deliberately never reset; a same-edge write is seen by the
   // next read, not this one.
   always_ff @(posedge clk) begin
      if (i_rdEn) begin
         r_rdData <= r_mem[i_rdIdx];
      end
      if (i_wrEn) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wrStrb[b]) begin
               r_mem[i_wrIdx][8*b +: 8] <= i_wrData[8*b +: 8];
            end
         end
      end
   end

   assign o_rdData = r_rdData;

endmodule : dmem_array
`default_nettype wire

// File: rtl/axi4l_dmem_slave.sv
`default_nettype none
// =============================================================================
// Module  : axi4l_dmem_slave
// Brief   : AXI4-Lite slave fronting a word-addressed data memory
// Revision: 1.0 - initial release
// =============================================================================
module axi4l_dmem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready
);

   localparam int              IDX_W   = ADDR_W - 2;
   localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0]  c_DEPTH = DEPTH[IDX_W:0];

   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return ({1'b0, a[ADDR_W-1:2]} < c_DEPTH);
   endfunction

   wState_t           r_wState, w_wNext;
   rState_t           r_rState, w_rNext;
   logic [ADDR_W-1:0] r_awAddr;
   logic [31:0]       r_wData;
   logic [3:0]        r_wStrb;
   logic [1:0]        r_bResp;
   logic [1:0]        r_rResp;
   logic              w_commit;
   logic [ADDR_W-1:0] w_cAddr;
   logic [31:0]       w_cData;
   logic [3:0]        w_cStrb;
   logic              w_memWe;
   logic              w_arHs;
   logic [31:0]       w_memQ;

   // ---------------------------------------------------------------- write FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_wState <= W_IDLE;
      else       r_wState <= w_wNext;
   end

   always_comb begin
      w_wNext   = r_wState;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      w_commit  = 1'b0;
      w_cAddr   = r_awAddr;
      w_cData   = r_wData;
      w_cStrb   = r_wStrb;
      case (r_wState)
         W_IDLE: begin
            s_awready = 1'b1;
            s_wready  = 1'b1;
            if (s_awvalid && s_wvalid) begin
               w_commit = 1'b1;
               w_cAddr  = s_awaddr;
               w_cData  = s_wdata;
               w_cStrb  = s_wstrb;
               w_wNext  = W_RESP;
            end else if (s_awvalid) begin
               w_wNext = W_WAIT_W;
            end else if (s_wvalid) begin
               w_wNext = W_WAIT_AW;
            end
         end
         W_WAIT_W: begin
            s_wready = 1'b1;
            if (s_wvalid) begin
               w_commit = 1'b1;
               w_cData  = s_wdata;
               w_cStrb  = s_wstrb;
               w_wNext  = W_RESP;
            end
         end
         W_WAIT_AW: begin
            s_awready = 1'b1;
            if (s_awvalid) begin
               w_commit = 1'b1;
               w_cAddr  = s_awaddr;
               w_wNext  = W_RESP;
            end
         end
         W_RESP: begin
            s_bvalid = 1'b1;
            if (s_bready) w_wNext = W_IDLE;
         end
         default: w_wNext = W_IDLE;
      endcase
      // Reset is asynchronous, so quiet the handshake outputs combinationally too.
      if (reset) begin
         s_awready = 1'b0;
         s_wready  = 1'b0;
         s_bvalid  = 1'b0;
         w_commit  = 1'b0;
         w_wNext   = W_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_awAddr <= '0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_bResp  <= RESP_OKAY;
      end else begin
         if (r_wState == W_IDLE && s_awvalid && !s_wvalid) r_awAddr <= s_awaddr;
         if (r_wState == W_IDLE && s_wvalid && !s_awvalid) begin
            r_wData <= s_wdata;
            r_wStrb <= s_wstrb;
         end
         if (w_commit) r_bResp <= inRange(w_cAddr) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign s_bresp = r_bResp;
   assign w_memWe = w_commit && inRange(w_cAddr) && (|w_cStrb);

   // ----------------------------------------------------------------- read FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rState <= R_IDLE;
      else       r_rState <= w_rNext;
   end

   always_comb begin
      w_rNext   = r_rState;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      case (r_rState)
         R_IDLE: begin
            s_arready = 1'b1;
            if (s_arvalid) w_rNext = R_DATA;
         end
         R_DATA: begin
            s_rvalid = 1'b1;
            if (s_rready) w_rNext = R_IDLE;
         end
         default: w_rNext = R_IDLE;
      endcase
      if (reset) begin
         s_arready = 1'b0;
         s_rvalid  = 1'b0;
         w_rNext   = R_IDLE;
      end
   end

   assign w_arHs = s_arvalid && s_arready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_rResp <= RESP_OKAY;
      else if (w_arHs) r_rResp <= inRange(s_araddr) ? RESP_OKAY : RESP_SLVERR;
   end

   assign s_rresp = r_rResp;
   assign s_rdata = (r_rState == R_DATA && r_rResp == RESP_OKAY) ? w_memQ : 32'd0;

   dmem_array #(
      .DEPTH  (DEPTH),
      .MEM_AW (MEM_AW)
   ) u_mem (
      .clk      (clk),
      .i_rdEn   (w_arHs),
      .i_rdIdx  (s_araddr[MEM_AW+1:2]),
      .o_rdData (w_memQ),
      .i_wrEn   (w_memWe),
      .i_wrIdx  (w_cAddr[MEM_AW+1:2]),
      .i_wrData (w_cData),
      .i_wrStrb (w_cStrb)
   );

endmodule : axi4l_dmem_slave
`default_nettype wire
